// File: rtl/srv_line_fill.sv
// srv_line_fill: refill engine that sits directly behind the instruction cache.
// A miss request makes it read four consecutive 32-bit words from a
// combinational, word-addressed ROM. It packs them into a 128-bit line and
// returns that line with a one-cycle response pulse.
//
// Handshake: ext_req_i is a level. It is sampled only in IDLE, and ext_addr_i
// is captured on the same edge. The requester keeps ext_req_i high until it
// sees ext_rsp_o=1, and drops it on that same edge. Request and address are
// ignored while busy. There is no queuing and no abort.
//
// Parameters:
//   WAIT_CYCLES  extra stall cycles before each word is captured (0..255)
// Ports:
//   clk          core clock
//   rst          asynchronous active-high reset
//   ext_req_i    line-fill request (level)
//   ext_addr_i   word address of the missed instruction; bits [1:0] ignored
//   ext_rsp_o    one-cycle pulse; line valid on ext_data_o
//   ext_data_o   line buffer; word k in bits [32k+31:32k]
//   rom_addr_o   registered word address presented to the ROM
//   rom_data_i   ROM read data, combinational from rom_addr_o
//   busy_o       high in FETCH and RESP
module srv_line_fill #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ext_req_i,
    input  logic [31:0]  ext_addr_i,
    output logic         ext_rsp_o,
    output logic [127:0] ext_data_o,
    output logic [31:0]  rom_addr_o,
    input  logic [31:0]  rom_data_i,
    output logic         busy_o
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [29:0]  base_q, base_d;
    logic [1:0]   idx_q, idx_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] line_q, line_d;
    logic [31:0]  rom_addr_q, rom_addr_d;

    // The low address bits select a word inside the line and are replaced by idx.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^ext_addr_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        rom_addr_d = rom_addr_q;

        case (state_q)
            IDLE: begin
                if (ext_req_i) begin
                    base_d     = ext_addr_i[31:2];
                    idx_d      = 2'd0;
                    cnt_d      = 8'd0;
                    // Present word 0 on the accepting edge, so the first
                    // capture can happen one cycle later when WAIT_CYCLES=0.
                    rom_addr_d = {ext_addr_i[31:2], 2'b00};
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q < WAIT_LIM) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    line_d[{idx_q, 5'b00000} +: 32] = rom_data_i;
                    if (idx_q == 2'd3) begin
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        // idx replaces the low bits, so the address never
                        // carries into base and never wraps to 0.
                        rom_addr_d = {base_q, idx_q + 2'd1};
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ext_rsp_o  = (state_q == RESP);
    assign busy_o     = (state_q != IDLE);
    assign ext_data_o = line_q;
    assign rom_addr_o = rom_addr_q;

endmodule

// File: tb/tb_srv_line_fill.sv
// Bench for srv_line_fill. Instance 0 uses WAIT_CYCLES=0 and instance 1 uses
// WAIT_CYCLES=2. Both are fed from a ROM whose contents are ROM[i] = i*0x11111111.
module tb_srv_line_fill;

    logic         clk;
    logic         rst;
    logic         req      [2];
    logic [31:0]  addr     [2];
    logic         rsp      [2];
    logic [127:0] data     [2];
    logic [31:0]  rom_addr [2];
    logic [31:0]  rom_data [2];
    logic         busy     [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    srv_line_fill #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .ext_req_i(req[0]), .ext_addr_i(addr[0]),
        .ext_rsp_o(rsp[0]), .ext_data_o(data[0]),
        .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]),
        .busy_o(busy[0])
    );

    srv_line_fill #(.WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .ext_req_i(req[1]), .ext_addr_i(addr[1]),
        .ext_rsp_o(rsp[1]), .ext_data_o(data[1]),
        .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]),
        .busy_o(busy[1])
    );

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return a * 32'h11111111;
    endfunction

    assign rom_data[0] = rom_f(rom_addr[0]);
    assign rom_data[1] = rom_f(rom_addr[1]);

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Reference model: a fill of address a returns words base..base+3 in
    // ascending order. The response comes 4*(W+1) cycles after acceptance,
    // and each address is presented for W+1 cycles. During the fetch,
    // ext_addr_i is driven to alt to show that it is ignored.
    task automatic do_fill(input int d, input logic [31:0] a, input logic [31:0] alt,
                           input bit keep_req);
        int w;
        int len;
        logic [31:0]  b;
        logic [127:0] line;
        logic [127:0] e;
        w = wait_of(d);
        len = 4 * (w + 1);
        b = a & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) line[32*k +: 32] = rom_f(b + 32'(k));
        exp_q.push_back(line);

        @(negedge clk);
        req[d] = 1'b1;
        addr[d] = a;
        @(posedge clk); #1;
        for (int k = 0; k < len; k++) begin
            check_eq("fetch_rom_addr", rom_addr[d], b + 32'(k / (w + 1)));
            check_eq("fetch_busy", busy[d], 1'b1);
            check_eq("fetch_rsp_low", rsp[d], 1'b0);
            @(negedge clk);
            addr[d] = alt;
            @(posedge clk); #1;
        end
        e = exp_q.pop_front();
        check_eq("rsp_pulse", rsp[d], 1'b1);
        check_eq("rsp_line", data[d], e);
        check_eq("rsp_busy", busy[d], 1'b1);
        check_eq("rsp_rom_addr_hold", rom_addr[d], b + 32'd3);
        @(negedge clk);
        if (!keep_req) req[d] = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_rsp_low", rsp[d], 1'b0);
        check_eq("idle_busy_low", busy[d], 1'b0);
        check_eq("idle_data_hold", data[d], e);
        check_eq("idle_rom_addr_hold", rom_addr[d], b + 32'd3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        logic [31:0] a;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            addr[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_rsp", rsp[i], 1'b0);
            check_eq("reset_data", data[i], '0);
            check_eq("reset_rom_addr", rom_addr[i], 32'd0);
            check_eq("reset_busy", busy[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_no_req_busy", busy[0], 1'b0);

        // Basic fill with no wait states.
        do_fill(0, 32'h0000_0005, 32'h0000_0005, 1'b0);
        // Slow memory.
        do_fill(1, 32'h0000_0010, 32'h0000_0010, 1'b0);
        // A new address shown while busy must be ignored.
        do_fill(0, 32'h0000_0008, 32'h0000_0040, 1'b0);
        do_fill(1, 32'h0000_0008, 32'h0000_0040, 1'b0);
        // Back-to-back: request held through RESP, next address in the IDLE cycle.
        do_fill(0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        do_fill(0, 32'h0000_0004, 32'h0000_0004, 1'b0);
        do_fill(1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        do_fill(1, 32'h0000_0004, 32'h0000_0004, 1'b0);

        // Reset mid-fill, after the second word is captured.
        @(negedge clk);
        req[0] = 1'b1;
        addr[0] = 32'h0000_0100;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp", rsp[0], 1'b0);
        check_eq("midrst_data", data[0], '0);
        check_eq("midrst_busy", busy[0], 1'b0);
        check_eq("midrst_rom_addr", rom_addr[0], 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check_eq("postrst_no_rsp", rsp[0], 1'b0);
            check_eq("postrst_idle", busy[0], 1'b0);
        end
        do_fill(0, 32'h0000_0020, 32'h0000_0020, 1'b0);

        // Top of memory: no wrap to address 0.
        do_fill(0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
        do_fill(1, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0);

        // Randomised fills, sometimes back-to-back.
        for (int i = 0; i < 16; i++) begin
            d = int'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_fill(d, a, $urandom, 1'b1);
                do_fill(d, $urandom, $urandom, 1'b0);
            end else begin
                do_fill(d, a, $urandom, 1'b0);
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/srv_line_fill.md
Name: srv_line_fill

Overview:
- Memory-side refill engine directly downstream of the instruction cache.
- On a cache-miss request it reads four consecutive 32-bit words from the combinational word-addressed ROM, one word per access slot.
- It assembles the words into a 128-bit line and returns the line with a one-cycle response pulse.
- WAIT_CYCLES models slow external memory.

Parameters:
- WAIT_CYCLES, 0: extra stall cycles before each word is captured; legal range 0..255.

Ports:
- clk  input  1  core clock (divided clock).
- rst  input  1  asynchronous active-high reset.
- ext_req_i  input  1  line-fill request from the cache; level signal.
- ext_addr_i  input  32  word address of the missed instruction; bits [1:0] are ignored.
- ext_rsp_o  output  1  one-cycle pulse; the line is valid on ext_data_o.
- ext_data_o  output  128  line data; word k occupies bits [32k+31:32k].
- rom_addr_o  output  32  word address presented to the ROM.
- rom_data_i  input  32  ROM read data; combinational from rom_addr_o.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - State returns to IDLE.
  - ext_rsp_o=0, ext_data_o=0, rom_addr_o=0, busy_o=0.
  - Word index and wait counter are cleared.
  - Reset is effective immediately, including mid-fill. A partial line is discarded and no response is produced.
- States: IDLE, FETCH, RESP.
- IDLE:
  - At a rising edge with ext_req_i=1: latch base = {ext_addr_i[31:2], 2'b00}.
  - Set word index idx=0 and wait count cnt=0, then go to FETCH.
  - With ext_req_i=0: stay in IDLE.
- FETCH:
  - rom_addr_o = base | idx, registered and updated on the same edge that changes idx.
  - If cnt < WAIT_CYCLES: cnt increments.
  - If cnt == WAIT_CYCLES: capture rom_data_i into line word idx and clear cnt.
    - If idx==3, go to RESP; otherwise idx increments.
  - Each word therefore takes exactly WAIT_CYCLES+1 cycles.
- RESP:
  - ext_rsp_o=1 for exactly one cycle, then IDLE on the next edge.
- Latency: if the request is accepted at edge N, ext_rsp_o is high between edges N+4*(WAIT_CYCLES+1) and N+4*(WAIT_CYCLES+1)+1.
- Requester contract: ext_req_i is held until the requester samples ext_rsp_o=1, and is deasserted on that same edge.
- ext_req_i and ext_addr_i are ignored in FETCH and RESP. No queuing and no abort.
- A request still high in the first IDLE cycle after RESP starts a new fill. Back-to-back fills are separated by exactly one IDLE cycle.
- ext_data_o:
  - It is the line buffer register and is guaranteed valid only while ext_rsp_o=1.
  - It holds its value in IDLE.
  - Words are overwritten in place during the next fill.
- Address arithmetic:
  - idx is 2 bits and is ORed into base[1:0], so there is no carry into base.
  - Base 0xFFFFFFFC yields 0xFFFFFFFC..0xFFFFFFFF with no wrap to 0.
- rom_addr_o holds its last value in IDLE and RESP.
- busy_o=1 in FETCH and RESP.

Test Plan:
- Basic fill (WAIT_CYCLES=0): ROM[i]=i*0x11111111; req with addr 0x00000005 at edge N.
  - rom_addr_o steps 4,5,6,7 on successive cycles.
  - ext_rsp_o is high for exactly the cycle after edge N+4.
  - ext_data_o = {ROM[7],ROM[6],ROM[5],ROM[4]}.
- Slow memory (WAIT_CYCLES=2): req addr 0x00000010.
  - Each address 0x10..0x13 is held 3 cycles.
  - Response after edge N+12 with ext_data_o = {ROM[0x13],ROM[0x12],ROM[0x11],ROM[0x10]}.
- Busy request ignored: during a fill of addr 0x8, change ext_addr_i to 0x40.
  - Returned line is still ROM[0x8..0xB].
  - rom_addr_o never shows 0x40 before the response.
- Back-to-back fills: req held high through RESP with addr 0x0, then 0x4 presented in the following IDLE cycle.
  - Second fill starts exactly one cycle after the RESP cycle and returns ROM[4..7].
- Reset mid-fill: assert rst asynchronously after the second word is captured.
  - Outputs clear immediately: rsp 0, data 0, busy 0.
  - No response pulse appears afterwards.
  - A new request for addr 0x20 completes normally.
- Top-of-memory address: req addr 0xFFFFFFFE.
  - rom_addr_o = 0xFFFFFFFC..0xFFFFFFFF with no wrap.
  - Line returned in correct word order.
